// File: rtl/mult_booth.sv
// Radix-2 Booth signed multiplier, one partial-product step per clock.
// Latency WIDTH+1 cycles from start to ready; start is ignored while busy.
module mult_booth #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] multiplicand,
    input  logic [WIDTH-1:0] multiplier,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             ready,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam int PW = 2*WIDTH + 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [WIDTH:0]     m;
    logic [PW-1:0]      p;
    logic [PW-1:0]      p_step;
    logic [CW-1:0]      cnt;
    logic [WIDTH:0]     acc;
    logic [2*WIDTH-1:0] prod;
    logic               accept;
    logic               last;

    assign accept = start && (state != RUN);
    assign last   = (cnt == CW'(WIDTH-1));

    // Accumulator is WIDTH+1 bits so subtracting the most negative M stays exact.
    always_comb begin
        acc = p[PW-1:WIDTH+1];
        case (p[1:0])
            2'b01:   acc = p[PW-1:WIDTH+1] + m;
            2'b10:   acc = p[PW-1:WIDTH+1] - m;
            default: acc = p[PW-1:WIDTH+1];
        endcase
    end

    assign p_step = {acc[WIDTH], acc, p[WIDTH:1]};
    assign prod   = p_step[2*WIDTH:1];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = accept ? RUN : IDLE;
            RUN:     state_nxt = last ? DONE : RUN;
            DONE:    state_nxt = accept ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy  = (state == RUN);
        ready = (state == DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            m        <= '0;
            p        <= '0;
            cnt      <= '0;
            result   <= '0;
            overflow <= 1'b0;
        end else if (accept) begin
            m   <= {multiplicand[WIDTH-1], multiplicand};
            p   <= {{(WIDTH+1){1'b0}}, multiplier, 1'b0};
            cnt <= '0;
        end else if (state == RUN) begin
            p   <= p_step;
            cnt <= cnt + CW'(1);
            if (last) begin
                result   <= prod[WIDTH-1:0];
                overflow <= ~(&prod[2*WIDTH-1:WIDTH-1]) && (|prod[2*WIDTH-1:WIDTH-1]);
            end
        end
    end

endmodule

// File: tb/tb_mult_booth.sv
// Bench for mult_booth: scoreboard of expected products and ready times, checked by a monitor.
module tb_mult_booth;

    localparam int WIDTH = 32;

    logic             clock;
    logic             reset;
    logic             start;
    logic [WIDTH-1:0] multiplicand;
    logic [WIDTH-1:0] multiplier;
    logic [WIDTH-1:0] result;
    logic             overflow;
    logic             ready;
    logic             busy;

    mult_booth #(.WIDTH(WIDTH)) dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .result       (result),
        .overflow     (overflow),
        .ready        (ready),
        .busy         (busy)
    );

    typedef struct {
        logic [WIDTH-1:0] res;
        logic             ovf;
        int               done_at;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    logic exp_rdy;
    logic exp_busy;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Reference: full signed product, then judge fit in WIDTH bits.
    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input int done_at);
        exp_t   e;
        longint pr;
        logic [63:0] pv;
        pr = longint'($signed(a)) * longint'($signed(b));
        pv = pr;
        e.res = pv[WIDTH-1:0];
        e.ovf = (pr != longint'($signed(pv[WIDTH-1:0])));
        e.done_at = done_at;
        return e;
    endfunction

    // Monitor: ready/busy timing against the oldest pending operation, and data on ready.
    always @(negedge clock) begin
        if (!reset) begin
            exp_rdy  = (q.size() > 0) && (cyc == q[0].done_at);
            exp_busy = (q.size() > 0) && (cyc < q[0].done_at) && (cyc >= q[0].done_at - WIDTH);
            if (ready !== exp_rdy) begin
                n_err++;
                $display("FAIL ready @cyc %0d: got %b want %b", cyc, ready, exp_rdy);
            end
            if (busy !== exp_busy) begin
                n_err++;
                $display("FAIL busy @cyc %0d: got %b want %b", cyc, busy, exp_busy);
            end
            if (exp_rdy) begin
                n_vec++;
                if (result !== q[0].res || overflow !== q[0].ovf) begin
                    n_err++;
                    $display("FAIL product @cyc %0d: got %h ovf %b want %h ovf %b",
                             cyc, result, overflow, q[0].res, q[0].ovf);
                end
                void'(q.pop_front());
            end else if (q.size() > 0 && cyc > q[0].done_at) begin
                void'(q.pop_front());
            end
        end
    end

    // Start goes high after a falling edge so exactly one rising edge samples it.
    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input bit accept);
        @(negedge clock);
        #2;
        start        = 1'b1;
        multiplicand = a;
        multiplier   = b;
        if (accept) q.push_back(model(a, b, cyc + 1 + WIDTH));
        @(posedge clock);
        #1;
        start        = 1'b0;
        multiplicand = $urandom;
        multiplier   = $urandom;
    endtask

    task automatic wait_done();
        int t = 0;
        while (q.size() != 0 && t < 200) begin
            @(negedge clock);
            t++;
        end
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL timeout: %0d results outstanding, want 0", q.size());
            q.delete();
        end
    endtask

    task automatic check_idle(input string tag);
        if (result !== '0 || overflow !== 1'b0 || ready !== 1'b0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL %s: got res %h ovf %b rdy %b busy %b want all zero",
                     tag, result, overflow, ready, busy);
        end
    endtask

    logic [WIDTH-1:0] dir_a[7] = '{32'd3, 32'hFFFFFFF9, 32'd6, 32'h80000000, 32'h80000000, 32'h00010000, 32'h0000FFFF};
    logic [WIDTH-1:0] dir_b[7] = '{32'd5, 32'd6, 32'hFFFFFFF9, 32'hFFFFFFFF, 32'd1, 32'h00010000, 32'h00008001};

    initial begin
        int d;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        reset        = 1'b0;
        start        = 1'b0;
        multiplicand = '0;
        multiplier   = '0;
        #1 reset = 1'b1;
        #2 check_idle("reset_state");
        repeat (2) @(negedge clock);
        #2 reset = 1'b0;

        for (int i = 0; i < 7; i++) begin
            issue(dir_a[i], dir_b[i], 1'b1);
            wait_done();
        end

        // Start during RUN is ignored; start in the DONE cycle is taken back-to-back.
        issue(32'd9, 32'd9, 1'b1);
        repeat (8) @(negedge clock);
        issue(32'd2, 32'd2, 1'b0);
        d = q[0].done_at;
        while (cyc < d - 1) @(negedge clock);
        issue(32'd4, 32'hFFFFFFFC, 1'b1);
        wait_done();

        // Asynchronous reset mid-operation aborts with no ready afterwards.
        issue(32'd100, 32'd100, 1'b1);
        repeat (14) @(negedge clock);
        #3 reset = 1'b1;
        q.delete();
        #1 check_idle("async_reset");
        @(negedge clock);
        #2 reset = 1'b0;
        repeat (40) @(negedge clock);
        issue(32'd0, 32'd12345, 1'b1);
        wait_done();

        // Random operands, mixing full-range and small values to exercise both overflow outcomes.
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 1) == 1) ra = 32'(int'($urandom_range(0, 131071)) - 65536);
            if ($urandom_range(0, 1) == 1) rb = 32'(int'($urandom_range(0, 131071)) - 65536);
            if (i % 4 == 3 && q.size() > 0) begin
                d = q[0].done_at;
                while (cyc < d - 1) @(negedge clock);
            end else begin
                wait_done();
            end
            issue(ra, rb, 1'b1);
        end
        wait_done();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
